// File: rtl/acc_seq_pkg.sv
// Shared types and default sizing for the frame accumulator sequencer.
package acc_seq_pkg;

  localparam int ACC_SEQ_DW_DEF      = 8;
  localparam int ACC_SEQ_MAX_LEN_DEF = 256;

  typedef enum logic [1:0] {
    IDLE,
    ACCUM,
    HOLD
  } acc_seq_state_e;

endpackage : acc_seq_pkg

// File: rtl/acc_core.sv
// Running-sum register with synchronous clear and enable; clear wins over enable.
module acc_core #(
  parameter int DW = 8,
  parameter int OW = 16
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          clr,
  input  logic          en,
  input  logic [DW-1:0] d,
  output logic [OW-1:0] sum
);

  // Accumulate zero-extended samples; clear restarts the sum for a new frame.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    if (rst) begin
      sum <= '0;
    end else if (clr) begin
      sum <= '0;
    end else if (en) begin
      sum <= sum + OW'(d);
    end
  end

endmodule : acc_core

// File: rtl/acc_frame_sequencer.sv
// Accepts a configured number of samples, sums them in acc_core and offers the
// frame total on a valid/ready output. A new frame may start on the same cycle
// the previous result is taken, so frames can run back-to-back.
module acc_frame_sequencer
  import acc_seq_pkg::*;
#(
  parameter  int DW      = ACC_SEQ_DW_DEF,
  parameter  int MAX_LEN = ACC_SEQ_MAX_LEN_DEF,
  localparam int LW      = $clog2(MAX_LEN + 1),
  localparam int OW      = DW + $clog2(MAX_LEN)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [LW-1:0] cfg_len,
  input  logic          start,
  input  logic          abort,
  output logic          busy,
  output logic          err,
  input  logic          s_valid,
  output logic          s_ready,
  input  logic [DW-1:0] s_data,
  output logic          m_valid,
  input  logic          m_ready,
  output logic [OW-1:0] m_data,
  output logic [LW-1:0] m_len
);

  localparam logic [LW-1:0] MAX_LEN_L = LW'(MAX_LEN);

  acc_seq_state_e state_q;
  acc_seq_state_e state_d;

  logic [LW-1:0] len_q;
  logic [LW-1:0] count_q;
  logic [OW-1:0] core_sum;

  logic cfg_ok;
  logic core_clr;
  logic core_en;
  logic err_set;
  logic last_beat;

  // A length is usable only if it is non-zero and fits the frame budget.
  assign cfg_ok    = (cfg_len != '0) && (cfg_len <= MAX_LEN_L);
  assign last_beat = core_en && (count_q == len_q - LW'(1));

  acc_core #(
    .DW (DW),
    .OW (OW)
  ) u_core (
    .clk (clk),
    .rst (rst),
    .clr (core_clr),
    .en  (core_en),
    .d   (s_data),
    .sum (core_sum)
  );

  // State register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state: abort beats completion in ACCUM; HOLD leaves only on handshake.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (start && cfg_ok) state_d = ACCUM;
      end
      ACCUM: begin
        if (abort)          state_d = IDLE;
        else if (last_beat) state_d = HOLD;
      end
      HOLD: begin
        if (m_ready) state_d = (start && cfg_ok) ? ACCUM : IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Per-state handshake outputs and accumulator control.
  always_comb begin
    // NOTE: every signal gets a default before the case so no latch is inferred.
    busy     = 1'b0;
    s_ready  = 1'b0;
    m_valid  = 1'b0;
    core_clr = 1'b0;
    core_en  = 1'b0;
    err_set  = 1'b0;
    case (state_q)
      IDLE: begin
        core_clr = start && cfg_ok;
        err_set  = start && !cfg_ok;
      end
      ACCUM: begin
        busy    = 1'b1;
        s_ready = 1'b1;
        core_en = s_valid && !abort;
      end
      HOLD: begin
        busy     = 1'b1;
        m_valid  = 1'b1;
        core_clr = m_ready && start && cfg_ok;
        err_set  = m_ready && start && !cfg_ok;
      end
      default: ;
    endcase
  end

  // Frame length/count tracking, error pulse and captured result.
  always_ff @(posedge clk) begin
    if (rst) begin
      len_q   <= '0;
      count_q <= '0;
      err     <= 1'b0;
      m_data  <= '0;
      m_len   <= '0;
    end else begin
      err <= err_set;
      if (core_clr) begin
        len_q   <= cfg_len;
        count_q <= '0;
      end else if (core_en) begin
        count_q <= count_q + LW'(1);
      end
      // The core only holds the pre-beat sum here, so fold in the final sample.
      if (last_beat) begin
        m_data <= core_sum + OW'(s_data);
        m_len  <= len_q;
      end
    end
  end

endmodule : acc_frame_sequencer

// File: tb/tb_acc_frame_sequencer.sv
// Directed bench for acc_frame_sequencer with a frame-level reference model
// compared against the DUT on every falling edge.
module tb_acc_frame_sequencer;

  localparam int DW      = 8;
  localparam int MAX_LEN = 256;
  localparam int LW      = 9;
  localparam int OW      = 16;

  logic          clk = 1'b0;
  logic          rst;
  logic [LW-1:0] cfg_len;
  logic          start;
  logic          abort;
  logic          busy;
  logic          err;
  logic          s_valid;
  logic          s_ready;
  logic [DW-1:0] s_data;
  logic          m_valid;
  logic          m_ready;
  logic [OW-1:0] m_data;
  logic [LW-1:0] m_len;

  acc_frame_sequencer #(
    .DW      (DW),
    .MAX_LEN (MAX_LEN)
  ) dut (
    .clk     (clk),
    .rst     (rst),
    .cfg_len (cfg_len),
    .start   (start),
    .abort   (abort),
    .busy    (busy),
    .err     (err),
    .s_valid (s_valid),
    .s_ready (s_ready),
    .s_data  (s_data),
    .m_valid (m_valid),
    .m_ready (m_ready),
    .m_data  (m_data),
    .m_len   (m_len)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;
  bit cmp_en  = 1'b0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Frame-level model: a frame is "collecting" until its sample quota is met,
  // then its total is "on offer" until the consumer takes it.
  bit collecting  = 1'b0;
  bit on_offer    = 1'b0;
  bit exp_err     = 1'b0;
  int remaining   = 0;
  int total       = 0;
  int frame_len   = 0;
  int res_data    = 0;
  int res_len     = 0;

  always @(posedge clk) begin
    if (rst) begin
      collecting = 1'b0;
      on_offer   = 1'b0;
      exp_err    = 1'b0;
      res_data   = 0;
      res_len    = 0;
    end else begin
      exp_err = 1'b0;
      if (collecting) begin
        if (abort) begin
          collecting = 1'b0;
        end else if (s_valid) begin
          total     += int'(s_data);
          remaining -= 1;
          if (remaining == 0) begin
            collecting = 1'b0;
            on_offer   = 1'b1;
            res_data   = total;
            res_len    = frame_len;
          end
        end
      end else if (!on_offer || m_ready) begin
        on_offer = 1'b0;
        if (start) begin
          if (int'(cfg_len) >= 1 && int'(cfg_len) <= MAX_LEN) begin
            collecting = 1'b1;
            frame_len  = int'(cfg_len);
            remaining  = frame_len;
            total      = 0;
          end else begin
            exp_err = 1'b1;
          end
        end
      end
    end
  end

  always @(negedge clk) begin
    if (cmp_en) begin
      check("busy",    64'(busy),    64'(collecting || on_offer));
      check("s_ready", 64'(s_ready), 64'(collecting));
      check("m_valid", 64'(m_valid), 64'(on_offer));
      check("m_data",  64'(m_data),  64'(res_data));
      check("m_len",   64'(m_len),   64'(res_len));
      check("err",     64'(err),     64'(exp_err));
    end
  end

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic start_frame(input int len);
    cfg_len = LW'(len);
    start   = 1'b1;
    tick();
    start   = 1'b0;
  endtask

  task automatic feed(input int v);
    s_valid = 1'b1;
    s_data  = DW'(v);
    tick();
  endtask

  initial begin
    rst     = 1'b1;
    cfg_len = '0;
    start   = 1'b0;
    abort   = 1'b0;
    s_valid = 1'b0;
    s_data  = '0;
    m_ready = 1'b0;
    tick();
    cmp_en = 1'b1;
    tick();
    rst = 1'b0;
    check("reset_busy",   64'(busy),    64'd0);
    check("reset_mvalid", 64'(m_valid), 64'd0);
    check("reset_mdata",  64'(m_data),  64'd0);
    tick();

    // T1: len 4, continuous samples, consumer always ready.
    m_ready = 1'b1;
    start_frame(4);
    check("t1_accum_busy", 64'(busy),    64'd1);
    check("t1_sready",     64'(s_ready), 64'd1);
    feed(10); feed(20); feed(30);
    check("t1_mvalid_early", 64'(m_valid), 64'd0);
    feed(40);
    s_valid = 1'b0;
    check("t1_mvalid", 64'(m_valid), 64'd1);
    check("t1_mdata",  64'(m_data),  64'd100);
    check("t1_mlen",   64'(m_len),   64'd4);
    tick();
    check("t1_idle_busy",  64'(busy),    64'd0);
    check("t1_mdata_kept", 64'(m_data),  64'd100);
    tick();

    // T2: len 3 with gaps, consumer stalls 5 cycles; abort ignored in HOLD.
    m_ready = 1'b0;
    start_frame(3);
    feed(5);
    s_valid = 1'b0; tick();
    feed(6);
    s_valid = 1'b0; tick(); tick();
    feed(7);
    for (int i = 0; i < 5; i++) begin
      abort = (i == 2);
      tick();
      check("t2_sready_hold", 64'(s_ready), 64'd0);
      check("t2_mdata_hold",  64'(m_data),  64'd18);
      check("t2_mvalid_hold", 64'(m_valid), 64'd1);
    end
    s_valid = 1'b0;
    abort   = 1'b0;
    m_ready = 1'b1;
    tick();
    check("t2_taken", 64'(m_valid), 64'd0);
    tick();

    // T3: maximum length, all-ones samples.
    m_ready = 1'b0;
    start_frame(256);
    for (int i = 0; i < 256; i++) begin
      feed(255);
      if (i == 254) check("t3_mvalid_early", 64'(m_valid), 64'd0);
    end
    s_valid = 1'b0;
    check("t3_mvalid", 64'(m_valid), 64'd1);
    check("t3_mdata",  64'(m_data),  64'd65280);
    check("t3_mlen",   64'(m_len),   64'd256);
    m_ready = 1'b1;
    tick();
    tick();

    // T4: illegal lengths.
    start_frame(0);
    check("t4_err0",  64'(err),  64'd1);
    check("t4_busy0", 64'(busy), 64'd0);
    tick();
    check("t4_err0_end", 64'(err), 64'd0);
    start_frame(MAX_LEN + 1);
    check("t4_err1",    64'(err),     64'd1);
    check("t4_sready1", 64'(s_ready), 64'd0);
    tick();

    // T5: abort mid-frame (with a beat present), then a short frame.
    start_frame(5);
    feed(1); feed(2);
    abort = 1'b1;
    feed(3);
    abort   = 1'b0;
    s_valid = 1'b0;
    check("t5_abort_idle",   64'(busy),    64'd0);
    check("t5_abort_mvalid", 64'(m_valid), 64'd0);
    tick();
    check("t5_no_output", 64'(m_valid), 64'd0);
    m_ready = 1'b0;
    start_frame(2);
    feed(7); feed(8);
    s_valid = 1'b0;
    check("t5_mdata", 64'(m_data), 64'd15);
    check("t5_mlen",  64'(m_len),  64'd2);
    tick();

    // T6: handshake plus start goes straight back to ACCUM with a cleared sum.
    m_ready = 1'b1;
    cfg_len = LW'(2);
    start   = 1'b1;
    tick();
    start   = 1'b0;
    check("t6_back_to_back_busy", 64'(busy),    64'd1);
    check("t6_back_to_back_rdy",  64'(s_ready), 64'd1);
    check("t6_mvalid_low",        64'(m_valid), 64'd0);
    m_ready = 1'b0;
    feed(9);
    s_valid = 1'b0;
    cfg_len = '0;
    start   = 1'b1;
    tick();
    start   = 1'b0;
    check("t6_start_in_accum_err", 64'(err), 64'd0);
    feed(4);
    s_valid = 1'b0;
    check("t6_mdata", 64'(m_data), 64'd13);
    tick();
    m_ready = 1'b1;
    cfg_len = '0;
    start   = 1'b1;
    tick();
    start   = 1'b0;
    check("t6_illegal_handshake_err",  64'(err),  64'd1);
    check("t6_illegal_handshake_idle", 64'(busy), 64'd0);
    tick();

    // Reset in the middle of a frame.
    m_ready = 1'b0;
    start_frame(4);
    feed(50); feed(60);
    s_valid = 1'b0;
    rst = 1'b1;
    tick();
    check("rst_mid_busy",   64'(busy),    64'd0);
    check("rst_mid_sready", 64'(s_ready), 64'd0);
    check("rst_mid_mdata",  64'(m_data),  64'd0);
    check("rst_mid_mlen",   64'(m_len),   64'd0);
    rst = 1'b0;
    tick();
    tick();

    cmp_en = 1'b0;
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule : tb_acc_frame_sequencer
